apb_register_bank: RTL and testbench
====================================

Name: apb_register_bank

Overview:
Parametrised APB-side configuration register bank with two write sources. The APB slave (apb_*) has priority over the accelerator write port (yjq_*). A yjq write that collides with an APB write is held in a one-entry deferral buffer and committed later; it is never dropped. Adds byte strobes on the APB port, a registered read port and per-register update pulses. All registers are exported as one flat bus to downstream peripherals.

Parameters:
REG_NUM, 8, number of registers; any value >= 2, not required to be a power of two
DATA_WIDTH, `APB_DATA_WIDTH, register width in bits; must be a multiple of 8
ADDR_WIDTH, $clog2(REG_NUM), register index width

Ports:
clk  input  1  system clock
resetn  input  1  reset, synchronous, active-low
apb_wen  input  1  APB write enable
apb_addr  input  ADDR_WIDTH  APB write register index
apb_wdata  input  DATA_WIDTH  APB write data
apb_wstrb  input  DATA_WIDTH/8  APB byte strobes; bit k enables byte k
apb_raddr  input  ADDR_WIDTH  read register index
apb_rdata  output  DATA_WIDTH  registered read data
yjq_wen  input  1  accelerator write request
yjq_addr  input  ADDR_WIDTH  accelerator write register index
yjq_wdata  input  DATA_WIDTH  accelerator write data; full-word write
yjq_ready  output  1  accelerator port can accept a write
regs_flat  output  REG_NUM*DATA_WIDTH  all registers; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
reg_update  output  REG_NUM  one-cycle pulse per register written in the previous cycle

Behaviour:
- Clock is clk. Reset is synchronous and active-low on resetn; all state is sampled on posedge clk only.
- Reset values:
  - all registers = 0, so regs_flat = 0
  - apb_rdata = 0, reg_update = 0
  - pending buffer empty, so yjq_ready = 1 in the cycle after reset
  - reset overrides any write in the same cycle; a pending write is discarded.
- yjq handshake:
  - A yjq write is accepted when yjq_wen & yjq_ready at a clock edge.
  - yjq_ready = ~pend_valid; combinational from state only, not from any input.
  - yjq_wen while yjq_ready = 0 is ignored. The requester must hold the request until it sees ready.
- Per-cycle commit priority:
  1. apb_wen = 1: APB write commits. Each strobed byte is replaced and unstrobed bytes are kept. apb_wstrb = 0 writes nothing, but the cycle still counts as an APB cycle.
     - If a yjq write is also accepted this cycle, it is captured into pend_addr/pend_data and pend_valid is set.
     - If pend_valid is already set, the pending write stays held.
  2. apb_wen = 0 and pend_valid = 1: the pending write commits and pend_valid clears. yjq_ready is 0 this cycle, so no new yjq write can be accepted.
  3. apb_wen = 0, pend_valid = 0, yjq write accepted: it commits directly, full word.
- Ordering on a collision to the same address: the APB write lands first and the deferred yjq write overwrites it in a later cycle.
- Maximum deferral: a pending write commits in the first cycle with apb_wen = 0. Back-to-back APB writes stall it indefinitely; this is permitted.
- Write latency: a write committed at edge N is visible on regs_flat after edge N. reg_update[i] is high for exactly the cycle following edge N.
  - It pulses even if the written value equals the old value.
  - It does not pulse for an APB write with apb_wstrb = 0.
- Out-of-range index (addr >= REG_NUM):
  - the write is discarded and no reg_update pulse is produced
  - a yjq write to an out-of-range index is still accepted and consumes its handshake; if deferred, it is dropped at drain time.
- Read: apb_rdata is loaded at every edge with register[apb_raddr] as it was before that edge's write.
  - Read-during-write to the same index returns the old value.
  - An out-of-range apb_raddr returns 0.
- No combinational path from any input to regs_flat, reg_update or apb_rdata.

Optional Feature:
APB_REG_LOCK_EN
- Defined: adds port lock_mask, input, width REG_NUM. A yjq write, direct or drained, to register i with lock_mask[i] = 1 at its commit cycle is dropped silently; the handshake still completes and no reg_update pulse is produced. APB writes ignore lock_mask.
- Undefined: no lock_mask port; every in-range register is writable from both ports.

Test Plan:
- Reset, then APB write addr 3, data 0xDEADBEEF, wstrb 0xF -> next cycle regs_flat R3 = 0xDEADBEEF, reg_update = 8'b0000_1000 for one cycle, others 0.
- R3 = 0xDEADBEEF; APB write addr 3, data 0x11223344, wstrb 4'b0101 -> R3 = 0xDE22BE44.
- Same cycle: APB addr 2, data 0xA; yjq addr 2, data 0xB -> next cycle R2 = 0xA, yjq_ready = 0; with apb_wen low the following cycle, R2 = 0xB, yjq_ready = 1; reg_update[2] pulses twice.
- Collision at addr 5, then 3 further APB writes to addr 0 -> pending held, yjq_ready = 0 throughout; R5 gets the yjq data one cycle after apb_wen drops.
- Pending write outstanding, resetn low for one cycle -> all registers 0, yjq_ready = 1, pending data never appears.
- REG_NUM = 6: yjq write addr 7 accepted -> no register changes, reg_update = 0. apb_raddr 7 -> apb_rdata = 0. Read of addr 1 concurrent with a write to addr 1 -> old value returned.

Source files
------------

// File: rtl/apb_register_bank_if.sv
// apb_register_bank_if: bus bundle for apb_register_bank.
//   APB side  : apb_wen/apb_addr/apb_wdata/apb_wstrb write; apb_raddr -> apb_rdata read
//   yjq side  : yjq_wen/yjq_addr/yjq_wdata request, yjq_ready accept
//   master    : drives requests, observes apb_rdata and yjq_ready
//   slave     : the register bank
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

interface apb_register_bank_if #(
  parameter int REG_NUM    = 8,
  parameter int DATA_WIDTH = `APB_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(REG_NUM)
);
  logic                    apb_wen;
  logic [ADDR_WIDTH-1:0]   apb_addr;
  logic [DATA_WIDTH-1:0]   apb_wdata;
  logic [DATA_WIDTH/8-1:0] apb_wstrb;
  logic [ADDR_WIDTH-1:0]   apb_raddr;
  logic [DATA_WIDTH-1:0]   apb_rdata;
  logic                    yjq_wen;
  logic [ADDR_WIDTH-1:0]   yjq_addr;
  logic [DATA_WIDTH-1:0]   yjq_wdata;
  logic                    yjq_ready;

  modport master (
    output apb_wen, apb_addr, apb_wdata, apb_wstrb, apb_raddr,
    output yjq_wen, yjq_addr, yjq_wdata,
    input  apb_rdata, yjq_ready
  );

  modport slave (
    input  apb_wen, apb_addr, apb_wdata, apb_wstrb, apb_raddr,
    input  yjq_wen, yjq_addr, yjq_wdata,
    output apb_rdata, yjq_ready
  );
endinterface

// File: rtl/apb_register_bank.sv
// apb_register_bank: configuration register bank with an APB write port
// (byte strobes, priority) and an accelerator (yjq) full-word write port.
// A yjq write that collides with an APB write is parked in a one-entry
// deferral buffer and commits in the first cycle without an APB write.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   bus           apb_register_bank_if.slave (APB + yjq signals)
//   lock_mask     per-register yjq write lock (only with APB_REG_LOCK_EN)
//   regs_flat     all registers, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_update    one-cycle pulse per register written at the previous edge
// Optional feature macro: APB_REG_LOCK_EN
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

// One register: APB strobed write wins over the yjq full-word write.
module apb_register_bank_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    apb_sel,
  input  logic [DATA_WIDTH/8-1:0] apb_wstrb,
  input  logic [DATA_WIDTH-1:0]   apb_wdata,
  input  logic                    yjq_sel,
  input  logic [DATA_WIDTH-1:0]   yjq_wdata,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    upd
);
  logic [DATA_WIDTH-1:0] d;
  logic                  wr;

  always_comb begin
    d  = q;
    wr = 1'b0;
    if (apb_sel) begin
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (apb_wstrb[b]) d[b*8 +: 8] = apb_wdata[b*8 +: 8];
      wr = |apb_wstrb;  // an all-zero strobe is no write at all
    end else if (yjq_sel) begin
      d  = yjq_wdata;
      wr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q   <= '0;
      upd <= 1'b0;
    end else begin
      q   <= d;
      upd <= wr;
    end
  end
endmodule

module apb_register_bank #(
  parameter int REG_NUM    = 8,
  parameter int DATA_WIDTH = `APB_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(REG_NUM)
) (
  input  logic                          clk,
  input  logic                          resetn,
  apb_register_bank_if.slave            bus,
`ifdef APB_REG_LOCK_EN
  input  logic [REG_NUM-1:0]            lock_mask,
`endif
  output logic [REG_NUM*DATA_WIDTH-1:0] regs_flat,
  output logic [REG_NUM-1:0]            reg_update
);
  logic [REG_NUM-1:0][DATA_WIDTH-1:0] regs;
  logic [REG_NUM-1:0]                 apb_sel, yjq_sel;

  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_data;

  logic                  yjq_acc, drain, y_vld;
  logic [ADDR_WIDTH-1:0] y_addr;
  logic [DATA_WIDTH-1:0] y_data;
  logic [DATA_WIDTH-1:0] rd_nxt, rdata_q;

  // Ready depends on state only, so no input-to-ready path exists.
  assign bus.yjq_ready = ~pend_valid;
  assign yjq_acc       = bus.yjq_wen & ~pend_valid;
  assign drain         = ~bus.apb_wen & pend_valid;
  // drain and a fresh accept are exclusive: accept needs pend_valid = 0
  assign y_vld         = drain | (~bus.apb_wen & yjq_acc);
  assign y_addr        = drain ? pend_addr : bus.yjq_addr;
  assign y_data        = drain ? pend_data : bus.yjq_wdata;

  // Out-of-range indices never match any register, so those writes vanish.
  for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
    assign apb_sel[i] = bus.apb_wen && (bus.apb_addr == ADDR_WIDTH'(i));
`ifdef APB_REG_LOCK_EN
    assign yjq_sel[i] = y_vld && (y_addr == ADDR_WIDTH'(i)) && !lock_mask[i];
`else
    assign yjq_sel[i] = y_vld && (y_addr == ADDR_WIDTH'(i));
`endif
    apb_register_bank_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
      .clk       (clk),
      .resetn    (resetn),
      .apb_sel   (apb_sel[i]),
      .apb_wstrb (bus.apb_wstrb),
      .apb_wdata (bus.apb_wdata),
      .yjq_sel   (yjq_sel[i]),
      .yjq_wdata (y_data),
      .q         (regs[i]),
      .upd       (reg_update[i])
    );
  end

  assign regs_flat = regs;

  // Reads see the pre-edge register contents; out-of-range reads give 0.
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < REG_NUM; i++)
      if (bus.apb_raddr == ADDR_WIDTH'(i)) rd_nxt = regs[i];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q    <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      rdata_q <= rd_nxt;
      if (bus.apb_wen && yjq_acc) begin
        pend_valid <= 1'b1;
        pend_addr  <= bus.yjq_addr;
        pend_data  <= bus.yjq_wdata;
      end else if (drain) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign bus.apb_rdata = rdata_q;
endmodule

// File: tb/tb_apb_register_bank.sv
// Scoreboard bench: each step pushes hand-computed post-edge expectations;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_apb_register_bank;
  localparam int RN = 6;
  localparam int DW = 32;
  localparam int AW = $clog2(RN);

  typedef struct {
    logic [RN*DW-1:0] flat;
    logic [RN-1:0]    upd;
    logic             rdy;
    logic [DW-1:0]    rd;
    string            name;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [RN*DW-1:0] regs_flat;
  logic [RN-1:0]    reg_update;
  logic [RN-1:0][DW-1:0] er;
  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  apb_register_bank_if #(.REG_NUM(RN), .DATA_WIDTH(DW)) bus ();

  apb_register_bank #(.REG_NUM(RN), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
`ifdef APB_REG_LOCK_EN
    .lock_mask  ('0),
`endif
    .regs_flat  (regs_flat),
    .reg_update (reg_update)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests += 4;
      if (regs_flat !== e.flat) begin
        n_fail++;
        $display("FAIL %s regs_flat got %h want %h", e.name, regs_flat, e.flat);
      end
      if (reg_update !== e.upd) begin
        n_fail++;
        $display("FAIL %s reg_update got %b want %b", e.name, reg_update, e.upd);
      end
      if (bus.yjq_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL %s yjq_ready got %b want %b", e.name, bus.yjq_ready, e.rdy);
      end
      if (bus.apb_rdata !== e.rd) begin
        n_fail++;
        $display("FAIL %s apb_rdata got %h want %h", e.name, bus.apb_rdata, e.rd);
      end
    end
  end

  // Drive one cycle of inputs, take the edge, then queue the expectation
  // for the state that edge produced (er must already hold the new regs).
  task automatic step(input logic rn, input logic aw, input logic [AW-1:0] aa,
                      input logic [DW-1:0] ad, input logic [3:0] as,
                      input logic [AW-1:0] ra, input logic yw,
                      input logic [AW-1:0] ya, input logic [DW-1:0] yd,
                      input logic [RN-1:0] e_upd, input logic e_rdy,
                      input logic [DW-1:0] e_rd, input string nm);
    exp_t e;
    resetn        = rn;
    bus.apb_wen   = aw;
    bus.apb_addr  = aa;
    bus.apb_wdata = ad;
    bus.apb_wstrb = as;
    bus.apb_raddr = ra;
    bus.yjq_wen   = yw;
    bus.yjq_addr  = ya;
    bus.yjq_wdata = yd;
    @(posedge clk);
    #1;
    e.flat = er;
    e.upd  = e_upd;
    e.rdy  = e_rdy;
    e.rd   = e_rd;
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    er = '0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, "reset");

    er[3] = 32'hDEADBEEF;
    step(1, 1, 3, 32'hDEADBEEF, 4'hF, 3, 0, 0, 0, 6'b001000, 1, 0, "apb_full_wr");
    step(1, 0, 0, 0, 0, 3, 0, 0, 0, 6'b000000, 1, 32'hDEADBEEF, "read_r3");

    er[3] = 32'hDE22BE44;
    step(1, 1, 3, 32'h11223344, 4'b0101, 3, 0, 0, 0, 6'b001000, 1, 32'hDEADBEEF, "apb_strb_wr");
    step(1, 0, 0, 0, 0, 3, 0, 0, 0, 6'b000000, 1, 32'hDE22BE44, "read_r3_strb");

    er[2] = 32'hA;
    step(1, 1, 2, 32'hA, 4'hF, 2, 1, 2, 32'hB, 6'b000100, 0, 0, "collide_apb");
    er[2] = 32'hB;
    step(1, 0, 0, 0, 0, 2, 0, 0, 0, 6'b000100, 1, 32'hA, "collide_drain");

    step(1, 1, 4, 32'hFFFFFFFF, 4'h0, 4, 0, 0, 0, 6'b000000, 1, 0, "zero_strb");

    er[5] = 32'h55;
    step(1, 1, 5, 32'h55, 4'hF, 0, 1, 5, 32'h5A5A, 6'b100000, 0, 0, "defer_r5");
    er[0] = 32'h1;
    step(1, 1, 0, 32'h1, 4'hF, 0, 1, 1, 32'h999, 6'b000001, 0, 0, "stall_1");
    er[0] = 32'h2;
    step(1, 1, 0, 32'h2, 4'hF, 0, 1, 1, 32'h999, 6'b000001, 0, 32'h1, "stall_2");
    er[0] = 32'h3;
    step(1, 1, 0, 32'h3, 4'hF, 0, 1, 1, 32'h999, 6'b000001, 0, 32'h2, "stall_3");
    er[5] = 32'h5A5A;
    step(1, 0, 0, 0, 0, 5, 0, 0, 0, 6'b100000, 1, 32'h55, "stall_drain");

    er[1] = 32'h77;
    step(1, 0, 0, 0, 0, 1, 1, 1, 32'h77, 6'b000010, 1, 0, "yjq_direct_rdw");
    step(1, 0, 0, 0, 0, 7, 1, 7, 32'h1234, 6'b000000, 1, 0, "yjq_oor");
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 1, 32'h77, "read_r1");

    er[0] = 32'hAA;
    step(1, 1, 0, 32'hAA, 4'b0001, 0, 1, 4, 32'hCAFE, 6'b000001, 0, 32'h3, "pend_before_rst");
    er = '0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, "rst_with_pend");
    step(1, 0, 0, 0, 0, 4, 0, 0, 0, 6'b000000, 1, 0, "pend_discarded");

    er[1] = 32'h10;
    step(1, 1, 1, 32'h10, 4'b0011, 0, 1, 6, 32'hBAD, 6'b000010, 0, 0, "defer_oor");
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 1, 32'h10, "drain_oor");
    er[1] = 32'h20;
    step(1, 1, 1, 32'h20, 4'hF, 1, 0, 0, 0, 6'b000010, 1, 32'h10, "apb_rdw");

    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
